// File: rtl/nms_stage.sv
// Streaming 3x3 non-maximum suppression over a raster of {magnitude, quantized angle} pixels.
// Optional NMS_LOW_THRESH_EN adds LOW_THRESH: interior centres below it are forced to zero.
module nms_stage #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int MAG_W  = 11
`ifdef NMS_LOW_THRESH_EN
    ,
    parameter int LOW_THRESH = 20
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    input  logic [1:0]       in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W-1:0] out_mag,
    output logic             out_last
);
    // Handshake: a transfer happens on a rising edge where valid && ready; a held
    // output (out_valid && !out_ready) keeps out_mag/out_last unchanged.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [MAG_W-1:0] out_mag_q, out_mag_d;

    // Line A holds the previous row with its angle (it becomes the window's middle row);
    // line B holds the row before that, whose angle is never consulted.
    logic [MAG_W+1:0] lb_a [WIDTH];
    logic [MAG_W-1:0] lb_b [WIDTH];

    // Window columns: m0 = col c-2, m1 = col c-1, new_mag = col c; index 0 top, 2 bottom.
    logic [2:0][MAG_W-1:0] m0_q, m1_q, new_mag;
    logic [1:0]            ang1_q;
    logic [MAG_W+1:0]      lb_a_rd;

    logic             accept, out_xfer, out_free, load, keep, border, center_last;
    logic [MAG_W-1:0] center, nb1, nb2, nms_mag, load_mag;

    assign lb_a_rd  = lb_a[in_col_q];
    assign new_mag  = {in_mag, lb_a_rd[MAG_W+1:2], lb_b[in_col_q]};
    assign center   = m1_q[1];
    assign out_xfer = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        nb1 = m0_q[1];
        nb2 = new_mag[1];
        case (ang1_q)
            2'd0: begin nb1 = m0_q[1];    nb2 = new_mag[1]; end
            2'd1: begin nb1 = new_mag[0]; nb2 = m0_q[2];    end
            2'd2: begin nb1 = m1_q[0];    nb2 = m1_q[2];    end
            default: begin nb1 = m0_q[0]; nb2 = new_mag[2]; end
        endcase
    end

`ifdef NMS_LOW_THRESH_EN
    assign keep = (center >= nb1) && (center >= nb2) && (center >= MAG_W'(LOW_THRESH));
`else
    assign keep = (center >= nb1) && (center >= nb2);
`endif

    // The output counters track the pixel whose result is loaded next.
    assign border = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                    (out_col_q == '0) || (out_col_q == COL_LAST);
    assign center_last = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
    assign nms_mag     = (keep && !border) ? center : '0;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_FILL:  in_ready = 1'b1;
            S_RUN:   in_ready = out_free;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_mag = nms_mag;
        case (state_q)
            S_FILL: begin
                if (accept && in_row_q == ROW_ONE && in_col_q == '0) state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_row_q == ROW_LAST && in_col_q == COL_LAST) state_d = S_FLUSH;
                end
            end
            default: begin
                // The trailing WIDTH+1 pixels are all on the border, so they emit zero.
                if (out_valid_q && out_last_q) begin
                    if (out_ready) state_d = S_FILL;
                end else if (out_free) begin
                    load     = 1'b1;
                    load_mag = '0;
                end
            end
        endcase

        in_col_d = in_col_q;
        in_row_d = in_row_q;
        if (accept) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end

        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q && !out_xfer;
        out_mag_d   = out_mag_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_mag_d   = load_mag;
            out_last_d  = center_last;
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
            end else begin
                out_col_d = out_col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_mag_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_mag_q   <= out_mag_d;
        end
    end

    // Pixel storage needs no reset: stale contents only ever reach border results.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_a[in_col_q] <= {in_mag, in_angle};
            lb_b[in_col_q] <= lb_a_rd[MAG_W+1:2];
            m0_q           <= m1_q;
            m1_q           <= new_mag;
            ang1_q         <= lb_a_rd[1:0];
        end
    end

    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_last  = out_last_q;

endmodule
